test_host: RTL and testbench

TEST_HOST -- requirements
Module: test_host

---
 rtl/test_host_pkg.sv | 28 ++
 rtl/test_host_ctr.sv | 17 +
 rtl/test_host.sv | 126 ++++++++++++
 tb/tb_test_host.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/test_host_pkg.sv
// rtl/test_host_pkg.sv - shared register map, status bits and state encoding for test_host
package test_host_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_RESP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] OFF_TOHOST   = 32'd0;
    localparam logic [31:0] OFF_FROMHOST = 32'd4;
    localparam logic [31:0] OFF_STATUS   = 32'd8;

    localparam int STAT_DONE    = 1;
    localparam int STAT_PASS    = 2;
    localparam int STAT_TIMEOUT = 3;

    function automatic logic [31:0] status_word(input logic timeout, input logic pass,
                                                input logic done);
        logic [31:0] w;
        w               = '0;
        w[STAT_DONE]    = done;
        w[STAT_PASS]    = pass;
        w[STAT_TIMEOUT] = timeout;
        return w;
    endfunction

endpackage

// File: rtl/test_host_ctr.sv
// rtl/test_host_ctr.sv - saturating cycle counter that holds whenever en is low
module test_host_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/test_host.sv
// rtl/test_host.sv - tohost/fromhost/status test host with optional watchdog (TEST_HOST_TIMEOUT_EN)
module test_host
    import test_host_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic [31:0] cycle_count
);

    state_t      state;
    logic [31:0] tohost;
    logic [31:0] rd_value;
    logic        accept;
    logic        is_tohost;
    logic        is_status;
    logic        finish_now;
    logic        expire;
    logic        ctr_en;

    assign accept     = req_valid && req_ready;
    assign is_tohost  = (req_addr == TOHOST_ADDR + OFF_TOHOST);
    assign is_status  = (req_addr == TOHOST_ADDR + OFF_STATUS);
    assign finish_now = accept && req_we && is_tohost && (state == ST_RUN) && !done
                        && req_wdata[0];

`ifdef TEST_HOST_TIMEOUT_EN
    logic timeout_q;

    assign expire = !done && (cycle_count == 32'(TIMEOUT_CYCLES - 1));

    // A finishing tohost write on the expiry edge wins over the watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else if (expire && !finish_now) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign ctr_en = !done && !finish_now && !expire;

    test_host_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (ctr_en),
        .count (cycle_count)
    );

    always_comb begin
        rd_value = '0;
        if (is_tohost) begin
            rd_value = tohost;
        end else if (is_status) begin
            rd_value = status_word(timeout, pass, done);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_code  <= '0;
            tohost     <= '0;
        end else begin
            case (state)
                ST_RESP: begin
                    state      <= done ? ST_HALT : ST_RUN;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    if (accept) begin
                        state      <= ST_RESP;
                        req_ready  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= rd_value;
                        if (req_we && is_tohost) begin
                            tohost <= req_wdata;
                        end
                    end else if (state == ST_RUN && done) begin
                        state <= ST_HALT;
                    end
                end
            endcase

            if (finish_now) begin
                done <= 1'b1;
                if (req_wdata == 32'd1) begin
                    pass <= 1'b1;
                end else begin
                    pass      <= 1'b0;
                    fail_code <= req_wdata[31:1];
                end
            end else if (expire) begin
                done <= 1'b1;
                pass <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_test_host.sv
// tb/tb_test_host.sv - randomized scoreboard bench for test_host
module tb_test_host;

`ifdef TEST_HOST_TIMEOUT_EN
    localparam int T   = 20;
    localparam bit TMO = 1'b1;
`else
    localparam int T   = 5000;
    localparam bit TMO = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;
    logic        timeout;
    logic [31:0] cycle_count;

    test_host #(.TOHOST_ADDR(BASE), .TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tick = '0;
    logic [31:0] rel_tick = '0;

    logic        m_done, m_pass, m_to;
    logic [30:0] m_fc;
    logic [31:0] m_tohost, m_frozen;

    always @(posedge clk) tick <= tick + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] edges();
        return tick - rel_tick;
    endfunction

    task automatic model_clear();
        m_done = 0; m_pass = 0; m_to = 0; m_fc = '0; m_tohost = '0; m_frozen = '0;
    endtask

    // Watchdog fires on the edge where the count equals T-1; anything later means it already fired.
    task automatic lapse(input logic [31:0] c);
        if (TMO && !m_done && c > 32'(T - 1)) begin
            m_done = 1; m_to = 1; m_pass = 0; m_frozen = 32'(T - 1);
        end
    endtask

    task automatic check_state(input string tag);
        lapse(edges());
        chk({tag, " done"}, 32'(done), 32'(m_done));
        chk({tag, " pass"}, 32'(pass), 32'(m_pass));
        chk({tag, " fail_code"}, 32'(fail_code), 32'(m_fc));
        chk({tag, " timeout"}, 32'(timeout), 32'(m_to));
        chk({tag, " cycle_count"}, cycle_count, m_done ? m_frozen : edges());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        req_valid = 0;
        exp_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1;
        rel_tick = tick;
    endtask

    // Called at a negedge; request is accepted at the following posedge.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] c, exp;
        int n;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("req_ready wait", 32'(req_ready), 32'd1);
            return;
        end
        c = edges();
        lapse(c);
        if (addr == BASE) exp = m_tohost;
        else if (addr == BASE + 32'd8) exp = {28'b0, m_to, m_pass, m_done, 1'b0};
        else exp = '0;
        if (we && addr == BASE) begin
            m_tohost = wdata;
            if (!m_done && wdata[0]) begin
                m_done = 1; m_frozen = c;
                if (wdata == 32'd1) m_pass = 1;
                else begin m_pass = 0; m_fc = wdata[31:1]; end
            end
        end
        if (TMO && !m_done && c == 32'(T - 1)) begin
            m_done = 1; m_to = 1; m_pass = 0; m_frozen = c;
        end
        exp_q.push_back(exp);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 0;
        chk("resp latency", 32'(resp_valid), 32'd1);
        @(negedge clk);
        chk("resp single cycle", 32'(resp_valid), 32'd0);
        check_state("post-req");
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("resp_valid in reset", 32'(resp_valid), 32'd0);
        end else if (resp_valid) begin
            if (exp_q.size() == 0) chk("unexpected resp", 32'(resp_valid), 32'd0);
            else chk("rdata", resp_rdata, exp_q.pop_front());
            chk("ready in RESP", 32'(req_ready), 32'd0);
        end else begin
            chk("idle rdata zero", resp_rdata, 32'd0);
            chk("idle ready", 32'(req_ready), 32'd1);
        end
    end

    initial begin
        logic [31:0] a, d;
        int n, k;
        model_clear();
        do_reset();
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        check_state("reset");

        // Non-finishing write, readback, status, fromhost and unmapped space.
        do_req(1, BASE, 32'h4);
        do_req(0, BASE, 32'h0);
        chk("even write keeps done low", 32'(done), 32'd0);
        do_req(0, BASE + 32'd8, 32'h0);
        do_req(1, BASE + 32'd4, 32'hDEAD_BEEF);
        do_req(0, BASE + 32'd4, 32'h0);
        do_req(1, 32'h0000_3000, 32'h1);
        do_req(0, 32'h0000_3000, 32'h0);
        check_state("unmapped write");

        // Pass, then a later failing write must not disturb the result.
        do_req(1, BASE, 32'h1);
        chk("pass done", 32'(done), 32'd1);
        chk("pass pass", 32'(pass), 32'd1);
        chk("pass fail_code", 32'(fail_code), 32'd0);
        do_req(0, BASE + 32'd8, 32'h0);
        do_req(1, BASE, 32'h5);
        chk("halt pass held", 32'(pass), 32'd1);
        chk("halt fail_code held", 32'(fail_code), 32'd0);
        do_req(0, BASE, 32'h0);
        repeat (10) @(negedge clk);
        check_state("frozen");

        // Fail path.
        do_reset();
        do_req(1, BASE, 32'h7);
        chk("fail done", 32'(done), 32'd1);
        chk("fail pass", 32'(pass), 32'd0);
        chk("fail code", 32'(fail_code), 32'd3);
        do_req(0, BASE + 32'd8, 32'h0);

        // Reset while a response is pending.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = BASE; req_wdata = '0;
        @(posedge clk);
        #1 rst = 0;
        req_valid = 0;
        #1;
        chk("async done", 32'(done), 32'd0);
        chk("async pass", 32'(pass), 32'd0);
        chk("async fail_code", 32'(fail_code), 32'd0);
        chk("async timeout", 32'(timeout), 32'd0);
        chk("async cycle_count", cycle_count, 32'd0);
        chk("async req_ready", 32'(req_ready), 32'd1);
        chk("async resp_valid", 32'(resp_valid), 32'd0);
        chk("async resp_rdata", resp_rdata, 32'd0);
        do_reset();
        do_req(0, BASE, 32'h0);

`ifdef TEST_HOST_TIMEOUT_EN
        do_reset();
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("wdog done", 32'(done), 32'd1);
        chk("wdog timeout", 32'(timeout), 32'd1);
        chk("wdog pass", 32'(pass), 32'd0);
        chk("wdog count", cycle_count, 32'(T - 1));
        repeat (5) @(negedge clk);
        check_state("wdog frozen");

        do_reset();
        while (edges() != 32'(T - 1)) @(negedge clk);
        do_req(1, BASE, 32'h1);
        chk("expiry race timeout", 32'(timeout), 32'd0);
        chk("expiry race pass", 32'(pass), 32'd1);
`endif

        for (int r = 0; r < 8; r++) begin
            do_reset();
            n = $urandom_range(4, 12);
            for (int i = 0; i < n; i++) begin
                k = $urandom_range(0, 4);
                case (k)
                    0, 1: a = BASE;
                    2: a = BASE + 32'd4;
                    3: a = BASE + 32'd8;
                    default: a = 32'h0000_2000 + ($urandom & 32'h0000_0FFC);
                endcase
                d = $urandom;
                if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
                if ($urandom_range(0, 7) == 0) d = 32'h1;
                do_req(1'($urandom_range(0, 1)), a, d);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            check_state("random end");
        end

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
